// File: rtl/fir_nibble_feeder_if.sv
// ---------------------------------------------------------------------------
// fir_nibble_feeder_if
//   Bundles the sample handshake and the PE0-facing outputs of the
//   nibble feeder.
//
//   Sample handshake (valid/ready):
//     A transfer happens on a rising clock edge where in_valid and in_ready
//     are both high. The source must hold in_data stable and keep in_valid
//     asserted until that edge. in_ready may change at any time and does not
//     depend on in_valid. Data offered while in_ready is low is not taken.
//
//   Signals:
//     in_valid  source -> feeder  sample valid
//     in_ready  feeder -> source  feeder can take a sample
//     in_data   source -> feeder  8-bit unsigned sample
//     Rdy       feeder -> PE0     frame-start pulse
//     x_nib     feeder -> PE0     Xin nibble stream
//     y_nib     feeder -> PE0     Yin nibble stream (bias seed)
//     busy      feeder -> status  FSM active or FIFO non-empty
//     frm_cnt   feeder -> status  number of Rdy pulses issued (wraps)
//
//   Modports: master = sample source / observer, slave = feeder.
// ---------------------------------------------------------------------------
interface fir_nibble_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       Rdy;
    logic [3:0] x_nib;
    logic [3:0] y_nib;
    logic       busy;
    logic [7:0] frm_cnt;

    modport master (
        output in_valid, in_data,
        input  in_ready, Rdy, x_nib, y_nib, busy, frm_cnt
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, Rdy, x_nib, y_nib, busy, frm_cnt
    );
endinterface

// File: rtl/fir_nibble_feeder.sv
// ---------------------------------------------------------------------------
// fir_nibble_feeder
//   Feeds the nibble-serial FIR PE chain. Samples arrive over a valid/ready
//   handshake into a 2-entry FIFO. For each sample the FSM emits one cycle
//   of Rdy, then four nibble cycles: X low/high nibble (then zeros) on x_nib
//   and the four nibbles of BIAS, LSB first, on y_nib. GAP idle cycles may
//   be inserted after each frame.
//
//   Parameters:
//     BIAS  16-bit accumulator seed streamed on y_nib
//     GAP   idle cycles between frames, 0..15
//
//   Ports:
//     i_clk        clock, rising edge
//     i_rst_n      synchronous active-low reset
//     bus          fir_nibble_feeder_if.slave (handshake + PE0 outputs)
//     o_dbg_state  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module fir_nibble_feeder #(
    parameter logic [15:0] BIAS = 16'h0000,
    parameter int unsigned GAP  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    fir_nibble_feeder_if.slave  bus,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_N0    = 3'd2,
        S_N1    = 3'd3,
        S_N2    = 3'd4,
        S_N3    = 3'd5,
        S_GAPW  = 3'd6
    } state_t;

    // Value loaded into the gap counter on leaving N3; the GAPW state then
    // lasts GAP cycles in total (counts GAP-1 down to 0).
    localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    state_t       r_state;
    state_t       w_next;
    logic [7:0]   r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic [7:0]   r_cur;
    logic [3:0]   r_gap_cnt;
    logic [7:0]   r_frm_cnt;

    logic         w_in_ready;
    logic         w_push;
    logic         w_pop;
    logic         w_fifo_ne;
    logic         w_rdy;
    logic [3:0]   w_x_nib;
    logic [3:0]   w_y_nib;

    assign w_in_ready = i_rst_n & (r_count != 2'd2);
    assign w_push     = bus.in_valid & w_in_ready;
    // Only entries present at the start of the cycle count, so a sample
    // pushed this cycle cannot be popped until the next one.
    assign w_fifo_ne  = (r_count != 2'd0);

    // Next-state and pop decision.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_ne) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_N0;
            S_N0:    w_next = S_N1;
            S_N1:    w_next = S_N2;
            S_N2:    w_next = S_N3;
            S_N3: begin
                if (GAP != 0) begin
                    w_next = S_GAPW;
                end else if (w_fifo_ne) begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_GAPW: begin
                if (r_gap_cnt == 4'd0) begin
                    if (w_fifo_ne) begin
                        w_pop  = 1'b1;
                        w_next = S_ISSUE;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        w_rdy   = 1'b0;
        w_x_nib = 4'd0;
        w_y_nib = 4'd0;
        case (r_state)
            S_ISSUE: w_rdy = 1'b1;
            S_N0: begin
                w_x_nib = r_cur[3:0];
                w_y_nib = BIAS[3:0];
            end
            S_N1: begin
                w_x_nib = r_cur[7:4];
                w_y_nib = BIAS[7:4];
            end
            S_N2:    w_y_nib = BIAS[11:8];
            S_N3:    w_y_nib = BIAS[15:12];
            default: begin
                w_rdy   = 1'b0;
                w_x_nib = 4'd0;
                w_y_nib = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_cur     <= 8'd0;
            r_gap_cnt <= 4'd0;
            r_frm_cnt <= 8'd0;
        end else begin
            r_state <= w_next;

            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_cur    <= r_mem[r_rd_ptr];
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (r_state == S_N3) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == S_GAPW) && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end

            if (r_state == S_ISSUE) begin
                r_frm_cnt <= r_frm_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.Rdy      = w_rdy;
    assign bus.x_nib    = w_x_nib;
    assign bus.y_nib    = w_y_nib;
    assign bus.busy     = (r_state != S_IDLE) | w_fifo_ne;
    assign bus.frm_cnt  = r_frm_cnt;
    assign o_dbg_state  = r_state;

endmodule
